// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared video types, state codes and default colours
package vid_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [10:0] coord_t;
  typedef logic [1:0]  state_t;

  localparam state_t ST_WAIT_FRAME = 2'd0;
  localparam state_t ST_RUN        = 2'd1;
  localparam state_t ST_DONE       = 2'd2;

  localparam rgb_t BORDER_C_DEF = 24'h000040;
  localparam rgb_t UFLOW_C_DEF  = 24'hFF0000;

endpackage

// File: rtl/raster_xy_counter.sv
// rtl/raster_xy_counter.sv - raster x/y position counters and frame-start edge detect
module raster_xy_counter
  import vid_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   vsync,
  input  logic   de,
  output coord_t x,
  output coord_t y,
  output logic   frame_start
);

  logic vsync_q;
  logic de_q;

  // vsync_q resets high so a reset taken while vsync is high needs a fresh low period first
  assign frame_start = vsync & ~vsync_q;

  // Registered copies of vsync and de for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      de_q    <= de;
    end
  end

  // Column: counts active cycles in the line, cleared when de falls
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
    end else if (de) begin
      x <= x + 11'd1;
    end else if (de_q) begin
      x <= '0;
    end
  end

  // Line: counts completed active lines since frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (frame_start) begin
      y <= '0;
    end else if (de_q && !de) begin
      y <= y + 11'd1;
    end
  end

endmodule

// File: rtl/img_window_reader.sv
// rtl/img_window_reader.sv - pulls gray pixels inside a fixed window and emits registered RGB888
module img_window_reader
  import vid_pkg::*;
#(
  parameter int unsigned IMG_W    = 225,
  parameter int unsigned IMG_H    = 225,
  parameter int unsigned WIN_X0   = 208,
  parameter int unsigned WIN_Y0   = 128,
  parameter rgb_t        BORDER_C = BORDER_C_DEF,
  parameter rgb_t        UFLOW_C  = UFLOW_C_DEF
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vsync,
  input  logic        i_hsync,
  input  logic        i_de,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_next,
  output logic [23:0] o_rgb,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_underflow,
  output logic        o_frame_done
);

  localparam coord_t X_LO   = coord_t'(WIN_X0);
  localparam coord_t X_END  = coord_t'(WIN_X0 + IMG_W);
  localparam coord_t X_LAST = coord_t'(WIN_X0 + IMG_W - 1);
  localparam coord_t Y_LO   = coord_t'(WIN_Y0);
  localparam coord_t Y_END  = coord_t'(WIN_Y0 + IMG_H);
  localparam coord_t Y_LAST = coord_t'(WIN_Y0 + IMG_H - 1);

  coord_t x;
  coord_t y;
  logic   frame_start;
  state_t state;
  logic   in_win;
  logic   last_px;

  raster_xy_counter u_xy (
    .clk         (clk),
    .rst         (rst),
    .vsync       (i_vsync),
    .de          (i_de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  // The frame-start cycle still carries the old y, so it is kept out of the window;
  // vsync low and reset also block reads from the loader.
  assign in_win = (state == ST_RUN) && i_de && i_vsync && !frame_start && !rst &&
                  (x >= X_LO) && (x < X_END) && (y >= Y_LO) && (y < Y_END);
  assign last_px = in_win && (x == X_LAST) && (y == Y_LAST);
  assign o_next  = in_win && i_valid;

  // Frame FSM: frame start always resyncs into RUN, last window pixel ends the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_FRAME;
    end else if (frame_start) begin
      state <= ST_RUN;
    end else if ((state == ST_RUN) && last_px) begin
      state <= ST_DONE;
    end
  end

  // Output register: pixel mux, delayed syncs/DE, sticky underflow and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rgb        <= '0;
      o_de         <= 1'b0;
      o_hsync      <= 1'b1;
      o_vsync      <= 1'b1;
      o_underflow  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_de         <= i_de;
      o_hsync      <= i_hsync;
      o_vsync      <= i_vsync;
      o_frame_done <= last_px;
      if (in_win && i_valid) begin
        o_rgb <= {i_data, i_data, i_data};
      end else if (in_win) begin
        o_rgb <= UFLOW_C;
      end else if (i_de) begin
        o_rgb <= BORDER_C;
      end else begin
        o_rgb <= '0;
      end
      if (frame_start) begin
        o_underflow <= 1'b0;
      end else if (in_win && !i_valid) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_img_window_reader.sv
// tb/tb_img_window_reader.sv - scoreboard bench for img_window_reader on a reduced raster
module tb_img_window_reader;

  localparam int H_TOT  = 24;
  localparam int H_ACT  = 18;
  localparam int HS_B   = 19;
  localparam int HS_E   = 22;
  localparam int V_TOT  = 16;
  localparam int V_ACT  = 12;
  localparam int VS_B   = 13;
  localparam int VS_E   = 15;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int WIN_X0 = 5;
  localparam int WIN_Y0 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vsync = 1'b1;
  logic        i_hsync = 1'b1;
  logic        i_de = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_next;
  logic [23:0] o_rgb;
  logic        o_de;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_underflow;
  logic        o_frame_done;

  img_window_reader #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .WIN_X0 (WIN_X0),
    .WIN_Y0 (WIN_Y0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_vsync      (i_vsync),
    .i_hsync      (i_hsync),
    .i_de         (i_de),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_next       (o_next),
    .o_rgb        (o_rgb),
    .o_de         (o_de),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_underflow  (o_underflow),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        uf;
    logic        fd;
  } exp_t;

  exp_t q_out[$];
  bit   q_nxt[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b1;
  int   nxt_cnt = 0;
  int   fd_cnt = 0;

  // Reference model: frame armed flag, position inside the raster, loader ramp
  bit m_run = 0;
  int m_col = 0;
  int m_line = 0;
  bit m_pvs = 1;
  bit m_pde = 0;
  bit m_uf = 0;
  int m_pix = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: o_next against this cycle's expectation, registered outputs against last cycle's
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_nxt.size() > 0) chk("o_next", {23'd0, o_next}, {23'd0, q_nxt.pop_front()});
      if (q_out.size() >= 2) begin
        exp_t e;
        e = q_out.pop_front();
        chk("o_rgb", o_rgb, e.rgb);
        chk("o_de", {23'd0, o_de}, {23'd0, e.de});
        chk("o_hsync", {23'd0, o_hsync}, {23'd0, e.hs});
        chk("o_vsync", {23'd0, o_vsync}, {23'd0, e.vs});
        chk("o_underflow", {23'd0, o_underflow}, {23'd0, e.uf});
        chk("o_frame_done", {23'd0, o_frame_done}, {23'd0, e.fd});
      end
      if (o_next === 1'b1) nxt_cnt++;
      if (o_frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic cycle(input bit r, input bit vs, input bit hs, input bit de, input bit valid);
    bit   fs, win, nxt, fd;
    exp_t e;
    logic [7:0] data;
    @(posedge clk);
    #1;
    if (!vs) m_pix = 0;
    fs   = !r && vs && !m_pvs;
    data = valid ? 8'(m_pix) : 8'($urandom);
    win  = !r && m_run && de && vs && !fs &&
           m_col >= WIN_X0 && m_col < WIN_X0 + IMG_W &&
           m_line >= WIN_Y0 && m_line < WIN_Y0 + IMG_H;
    nxt  = win && valid;
    fd   = win && m_col == WIN_X0 + IMG_W - 1 && m_line == WIN_Y0 + IMG_H - 1;
    rst = r; i_vsync = vs; i_hsync = hs; i_de = de; i_valid = valid; i_data = data;
    if (r) begin
      e = '{rgb: 24'h0, de: 1'b0, hs: 1'b1, vs: 1'b1, uf: 1'b0, fd: 1'b0};
      m_run = 0; m_col = 0; m_line = 0; m_pvs = 1; m_pde = 0; m_uf = 0;
    end else begin
      m_uf = fs ? 1'b0 : (m_uf | (win && !valid));
      e.rgb = nxt ? {3{data}} : win ? 24'hFF0000 : de ? 24'h000040 : 24'h0;
      e.de = de; e.hs = hs; e.vs = vs; e.uf = m_uf; e.fd = fd;
      if (fs) m_run = 1;
      else if (fd) m_run = 0;
      if (fs) m_line = 0;
      else if (m_pde && !de) m_line++;
      m_col = de ? m_col + 1 : 0;
      m_pvs = vs; m_pde = de;
    end
    if (nxt) m_pix++;
    q_nxt.push_back(nxt);
    q_out.push_back(e);
  endtask

  // mode 0: valid tied high, 1: random valid, 2: vsync glitch mid-window,
  // 3: reset mid-window, 4: 3-cycle underflow burst at line 5
  task automatic run_frame(input int mode);
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        bit de, hs, vs, valid, r;
        de    = (v < V_ACT) && (h < H_ACT);
        hs    = !((h >= HS_B) && (h < HS_E));
        vs    = !((v >= VS_B) && (v < VS_E));
        valid = 1'b1;
        r     = 1'b0;
        if (mode == 1 || mode == 2 || mode == 3) valid = ($urandom_range(0, 7) != 0);
        if (mode == 2 && v == 5 && h >= 19 && h < 22) vs = 1'b0;
        if (mode == 3 && v == 5 && h == 7) r = 1'b1;
        if (mode == 4 && v == 5 && h >= 8 && h < 11) valid = 1'b0;
        cycle(r, vs, hs, de, valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_rgb", o_rgb, 24'h0);
    chk("reset_hsync", {23'd0, o_hsync}, 24'd1);
    chk("reset_vsync", {23'd0, o_vsync}, 24'd1);
    chk("reset_underflow", {23'd0, o_underflow}, 24'd0);
    chk("reset_next", {23'd0, o_next}, 24'd0);

    run_frame(0);
    nxt_cnt = 0; fd_cnt = 0;
    run_frame(0);
    chk("full_frame_reads", 24'(nxt_cnt), 24'(IMG_W * IMG_H));
    chk("full_frame_done", 24'(fd_cnt), 24'd1);

    nxt_cnt = 0; fd_cnt = 0;
    run_frame(4);
    chk("uflow_frame_reads", 24'(nxt_cnt), 24'(IMG_W * IMG_H - 3));
    chk("uflow_frame_done", 24'(fd_cnt), 24'd1);

    for (int f = 0; f < 6; f++) run_frame(1);

    fd_cnt = 0;
    run_frame(2);
    chk("glitch_frame_done", 24'(fd_cnt), 24'd0);
    run_frame(1);

    nxt_cnt = 0; fd_cnt = 0;
    run_frame(3);
    chk("reset_frame_done", 24'(fd_cnt), 24'd0);
    chk("reset_frame_reads_bound", 24'(nxt_cnt <= 2 * IMG_W + 2), 24'd1);
    for (int f = 0; f < 3; f++) run_frame(1);
    run_frame(0);

    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
